// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes (RISC-V funct3), FSM states
// and the access legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    STORE,
    RESP
  } lsu_state_e;

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic access_fault(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] offset);
    case (funct3)
      LSU_B:   return 1'b0;
      LSU_H:   return offset[0];
      LSU_W:   return offset != 2'b00;
      LSU_BU:  return store;
      LSU_HU:  return store | offset[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word[{offset, 3'b000} +: 8];
    half_sel    = offset[1] ? word[31:16] : word[15:0];
    load_data   = '0;
    merged_word = word;
    case (size)
      LSU_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU: load_data = {24'h0, byte_sel};
      LSU_H:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU: load_data = {16'h0, half_sel};
      LSU_W:  load_data = word;
      default: load_data = '0;
    endcase
    case (size)
      LSU_B, LSU_BU: merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
      LSU_H, LSU_HU: begin
        if (offset[1]) merged_word[31:16] = wdata[15:0];
        else           merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator for a word-wide memory without byte enables;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  lsu_state_e       state;
  logic             cap_store;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_offset;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_wdata;
  logic [31:0]      merged_q;
  logic [31:0]      load_data;
  logic [31:0]      merged_word;
  logic             req_fault;
  logic             unused_addr_hi;

  // Word index wraps modulo the power-of-two depth, so the upper address bits are dropped.
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];
  assign req_fault      = access_fault(req_store, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .offset      (cap_offset),
    .size        (cap_funct3),
    .word        (mem_rd_data),
    .wdata       (cap_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cap_store  <= 1'b0;
      cap_funct3 <= '0;
      cap_offset <= '0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
      merged_q   <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_store  <= req_store;
            cap_funct3 <= req_funct3;
            cap_offset <= req_addr[1:0];
            cap_idx    <= req_addr[IDX_W+1:2];
            cap_wdata  <= req_wdata;
            if (req_fault) begin
              resp_rdata <= '0;
              resp_fault <= 1'b1;
              state      <= RESP;
            end else if (!req_store) begin
              state <= LOAD;
            end else if (req_funct3 == LSU_W) begin
              state <= STORE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        RMW_READ: begin
          merged_q <= merged_word;
          state    <= STORE;
        end
        STORE: begin
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode from the asynchronously reset state, so a reset drops them at once.
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign mem_rd_en   = (state == LOAD) || (state == RMW_READ);
  assign mem_wr_en   = (state == STORE);
  assign mem_addr    = (state == IDLE) ? '0 : 32'(cap_idx);
  assign mem_wr_data = (state != STORE) ? '0 :
                       (cap_funct3 == LSU_W) ? cap_wdata : merged_q;

  logic unused_cap_store;
  assign unused_cap_store = cap_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  logic [31:0] mem [0:31];
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          resp_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] last_rd_addr = '0;
  logic [32:0] resp_log [$];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  assign mem_rd_data = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[4:0]] <= mem_wr_data;
    if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    if (resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      resp_log.push_back({resp_fault, resp_rdata});
    end
    if (mem_rd_en) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
    if (mem_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wr_data;
    end
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                     input logic exp_fault, input logic [31:0] exp_rdata,
                     input int exp_rd, input int exp_wr);
    int rd0;
    int wr0;
    int lat;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    check({tag, "_ready"}, 33'(req_ready), 33'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 33'(lat), 33'(exp_lat));
    check({tag, "_fault"}, 33'(resp_fault), 33'(exp_fault));
    check({tag, "_rdata"}, 33'(resp_rdata), 33'(exp_rdata));
    @(negedge clk);
    check({tag, "_rd"}, 33'(rd_cnt - rd0), 33'(exp_rd));
    check({tag, "_wr"}, 33'(wr_cnt - wr0), 33'(exp_wr));
    check({tag, "_idle"}, 33'(req_ready), 33'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          resp0;
    int          wr0;
    int          hs0;
    int          log0;
    int          w;
    logic        bb_st   [4];
    logic [2:0]  bb_f3   [4];
    logic [31:0] bb_addr [4];
    logic [31:0] bb_wd   [4];
    logic [32:0] bb_exp  [4];

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 33'(req_ready), 33'(1));
    check("rst_resp_valid", 33'(resp_valid), 33'(0));
    check("rst_rdata", 33'(resp_rdata), 33'(0));
    check("rst_fault", 33'(resp_fault), 33'(0));
    check("rst_mem_addr", 33'(mem_addr), 33'(0));
    check("rst_rd_en", 33'(mem_rd_en), 33'(0));
    check("rst_wr_en", 33'(mem_wr_en), 33'(0));
    check("rst_wr_data", 33'(mem_wr_data), 33'(0));
    reset = 1'b0;
    @(negedge clk);

    // SW 0x8 with per-cycle observation
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0008;
    req_wdata  = 32'hDEAD_BEEF;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("sw_wr_en", 33'(mem_wr_en), 33'(1));
    check("sw_rd_en", 33'(mem_rd_en), 33'(0));
    check("sw_addr", 33'(mem_addr), 33'(2));
    check("sw_wr_data", 33'(mem_wr_data), 33'(32'hDEAD_BEEF));
    check("sw_busy", 33'(req_ready), 33'(0));
    @(negedge clk);
    check("sw_resp", 33'(resp_valid), 33'(1));
    check("sw_wr_off", 33'(mem_wr_en), 33'(0));
    check("sw_wr_data_off", 33'(mem_wr_data), 33'(0));
    check("sw_mem", 33'(mem[2]), 33'(32'hDEAD_BEEF));
    @(negedge clk);
    check("sw_ready_again", 33'(req_ready), 33'(1));
    check("sw_resp_off", 33'(resp_valid), 33'(0));

    run("lw8", 1'b0, 3'b010, 32'h8, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 1, 0);

    run("sw_pat", 1'b1, 3'b010, 32'h8, 32'h80FF_7F01, 2, 1'b0, 32'h0, 0, 1);
    run("lb_b", 1'b0, 3'b000, 32'hB, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 1, 0);
    run("lbu_b", 1'b0, 3'b100, 32'hB, 32'h0, 2, 1'b0, 32'h0000_0080, 1, 0);
    run("lh_a", 1'b0, 3'b001, 32'hA, 32'h0, 2, 1'b0, 32'hFFFF_80FF, 1, 0);
    run("lhu_8", 1'b0, 3'b101, 32'h8, 32'h0, 2, 1'b0, 32'h0000_7F01, 1, 0);
    run("lb_9", 1'b0, 3'b000, 32'h9, 32'h0, 2, 1'b0, 32'h0000_007F, 1, 0);

    run("sw_restore", 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 0, 1);
    run("sb_9", 1'b1, 3'b000, 32'h9, 32'hAAAA_AA55, 3, 1'b0, 32'h0, 1, 1);
    check("sb_wr_addr", 33'(last_wr_addr), 33'(2));
    check("sb_wr_data", 33'(last_wr_data), 33'(32'hDEAD_55EF));
    check("sb_mem", 33'(mem[2]), 33'(32'hDEAD_55EF));
    run("sh_a", 1'b1, 3'b001, 32'hA, 32'hFFFF_1234, 3, 1'b0, 32'h0, 1, 1);
    check("sh_mem", 33'(mem[2]), 33'(32'h1234_55EF));

    run("lw_pre_fault", 1'b0, 3'b010, 32'h8, 32'h0, 2, 1'b0, 32'h1234_55EF, 1, 0);
    run("flt_lw6", 1'b0, 3'b010, 32'h6, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run("flt_sh3", 1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 0);
    run("flt_f011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run("flt_sbu", 1'b1, 3'b100, 32'h0, 32'h1, 1, 1'b1, 32'h0, 0, 0);
    check("flt_mem", 33'(mem[2]), 33'(32'h1234_55EF));

    // index wraps modulo depth: byte address 0x88 is word 34 -> word 2
    run("lw_wrap", 1'b0, 3'b010, 32'h88, 32'h0, 2, 1'b0, 32'h1234_55EF, 1, 0);
    check("lw_wrap_addr", 33'(last_rd_addr), 33'(2));

    // reset asserted during STORE, before its commit edge
    resp0      = resp_cnt;
    wr0        = wr_cnt;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h8;
    req_wdata  = 32'hCAFE_F00D;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_wr_en_before", 33'(mem_wr_en), 33'(1));
    #2 reset = 1'b1;
    #1;
    check("rstw_wr_en_drop", 33'(mem_wr_en), 33'(0));
    check("rstw_wr_data", 33'(mem_wr_data), 33'(0));
    check("rstw_addr", 33'(mem_addr), 33'(0));
    check("rstw_ready", 33'(req_ready), 33'(1));
    @(negedge clk);
    check("rstw_mem", 33'(mem[2]), 33'(32'h1234_55EF));
    check("rstw_resp_valid", 33'(resp_valid), 33'(0));
    check("rstw_rdata", 33'(resp_rdata), 33'(0));
    check("rstw_fault", 33'(resp_fault), 33'(0));
    check("rstw_no_resp", 33'(resp_cnt - resp0), 33'(0));
    check("rstw_no_write", 33'(wr_cnt - wr0), 33'(0));
    reset = 1'b0;
    @(negedge clk);

    // req_valid held high across four mixed requests
    bb_st[0] = 1'b1; bb_f3[0] = 3'b010; bb_addr[0] = 32'h10; bb_wd[0] = 32'h1122_3344;
    bb_st[1] = 1'b0; bb_f3[1] = 3'b010; bb_addr[1] = 32'h10; bb_wd[1] = 32'h0;
    bb_st[2] = 1'b0; bb_f3[2] = 3'b000; bb_addr[2] = 32'h13; bb_wd[2] = 32'h0;
    bb_st[3] = 1'b0; bb_f3[3] = 3'b001; bb_addr[3] = 32'h11; bb_wd[3] = 32'h0;
    bb_exp[0] = {1'b0, 32'h0};
    bb_exp[1] = {1'b0, 32'h1122_3344};
    bb_exp[2] = {1'b0, 32'h0000_0011};
    bb_exp[3] = {1'b1, 32'h0};
    hs0   = hs_cnt;
    resp0 = resp_cnt;
    log0  = resp_log.size();
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_store  = bb_st[k];
      req_funct3 = bb_f3[k];
      req_addr   = bb_addr[k];
      req_wdata  = bb_wd[k];
      w = 0;
      while (!req_ready && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("bb_ready_wait", 33'(req_ready), 33'(1));
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    w = 0;
    while ((resp_cnt - resp0) < 4 && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    @(negedge clk);
    check("bb_handshakes", 33'(hs_cnt - hs0), 33'(4));
    check("bb_responses", 33'(resp_cnt - resp0), 33'(4));
    for (int k = 0; k < 4; k++) begin
      if (resp_log.size() > log0 + k)
        check($sformatf("bb_resp%0d", k), resp_log[log0 + k], bb_exp[k]);
      else
        check($sformatf("bb_resp%0d_missing", k), 33'(resp_log.size()), 33'(log0 + k + 1));
    end
    check("rd_wr_exclusive", 33'(both_cnt), 33'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-wide data memory. Accepts one RISC-V load/store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW) and converts the byte address to a word index. Performs sub-word stores as read-modify-write, because the memory has no byte enables. Returns aligned, extended load data and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- DEPTH_WORDS, 32, memory depth in words; word index is taken modulo DEPTH_WORDS (power of two).

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and faults
- resp_fault  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  out  32  word index = req_addr[31:2] mod DEPTH_WORDS, zero-extended
- mem_rd_en  out  1  read strobe
- mem_rd_data  in  32  combinational read data, valid in the cycle mem_rd_en is high
- mem_wr_en  out  1  write strobe; memory writes on the same rising edge
- mem_wr_data  out  32  full word to write

## Operation
- States: IDLE, LOAD, RMW_READ, STORE, RESP.
- IDLE: on handshake, capture store, funct3, addr and wdata into registers, then:
  - fault → RESP with fault=1;
  - load → LOAD;
  - SW → STORE;
  - SB/SH → RMW_READ.
- Fault conditions:
  - funct3 ∈ {011, 110, 111};
  - store with funct3[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0.
- LOAD: mem_rd_en=1. Extract from mem_rd_data by addr[1:0]: byte at bits [8b+7:8b], half at [16h+15:16h]. Sign-extend for B/H, zero-extend for BU/HU, pass W. Register the result into resp_rdata, then → RESP.
- RMW_READ: mem_rd_en=1. Register the merged word (old word with the target byte/half replaced by req_wdata[7:0]/[15:0]), then → STORE.
- STORE: mem_wr_en=1, mem_wr_data = wdata (SW) or merged word. → RESP.
- RESP: resp_valid=1, then → IDLE.
- mem_* outputs decode from the state and captured registers only; there is no combinational path from req_* to mem_*.
- mem_addr holds the captured index in all non-IDLE states and is 0 in IDLE. mem_wr_data is 0 outside STORE.
- Only one of mem_rd_en / mem_wr_en is ever high.

## Timing
- Handshake at edge N. Fault: resp_valid in cycle N+1.
- Load and SW: memory cycle N+1, resp_valid N+2, req_ready high again N+3.
- SB/SH: read N+1, write N+2, resp_valid N+3.
- resp_rdata and resp_fault are held until the next response.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, all mem_* 0.
- Reset mid-operation drops mem_wr_en asynchronously. A STORE cycle cut by reset before the edge does not commit, and no response is issued.
- req_valid is ignored outside IDLE. Back-to-back requests incur one idle gap cycle (RESP).

## Structure
- Shared package lsu_pkg:
  - funct3 constants/enum mem_size_e (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - lsu_state_e.
- One combinational sub-module, lsu_align, for load extract/extend and store merge: inputs offset, size, word, wdata; outputs load_data, merged_word. It is unit-testable alone.

## Test plan
- SW addr 0x0000_0008 data 0xDEADBEEF → mem_wr_en one cycle, mem_addr 2, mem_wr_data 0xDEADBEEF; then LW 0x8 → resp_rdata 0xDEADBEEF, latency 2.
- Word 2 = 0x80FF7F01: LB 0xB → 0xFFFFFF80; LBU 0xB → 0x00000080; LH 0xA → 0xFFFF80FF; LHU 0x8 → 0x00007F01.
- SB addr 0x9 data 0x55 with word 2 = 0xDEADBEEF → read then write 0xDEAD55EF; resp_valid at N+3; SH addr 0xA data 0x1234 → 0x123455EF.
- LW addr 0x6, SH addr 0x3, funct3 011, store funct3 100 → resp_fault=1 at N+1, resp_rdata 0, mem_rd_en and mem_wr_en never high.
- Assert reset during STORE, before the edge → mem_wr_en falls immediately, memory word unchanged, all outputs at reset values, req_ready 1.
- req_valid held high across 4 mixed requests → exactly 4 handshakes, only in IDLE, 4 resp_valid pulses in order.
